dbj_decoder: RTL and testbench
==============================

DBJ_DECODER -- requirements
Module: dbj_decoder

Interface
REQ-001 SHALL have parameter N, default 4, window width in bits.
REQ-002 SHALL have parameter SEQ, default 16'b0000_1001_1010_1111, the 2^N-bit B(2,N) reference sequence; index 0 is SEQ MSB.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port bit_in  input  1  serial sequence bit from the generator.
REQ-006 SHALL have port bit_valid  input  1  bit_in is valid this cycle.
REQ-007 SHALL have port bit_ready  output  1  decoder accepts a bit this cycle.
REQ-008 SHALL have port pos  output  N  decoded index of the most recent window.
REQ-009 SHALL have port pos_valid  output  1  one-cycle pulse marking a new pos.
REQ-010 SHALL have port locked  output  1  decoder is tracking a known position.
REQ-011 SHALL have port slip  output  1  one-cycle pulse: tracked window mismatched its prediction.
REQ-012 SHALL have port miss  output  1  one-cycle pulse: search found no matching window.

Function
REQ-013 SHALL treat a bit as accepted only in cycles with bit_valid=1 and bit_ready=1; bit_valid while bit_ready=0 is ignored and the source holds it.
REQ-014 SHALL shift each accepted bit into an N-bit window register at the LSB; the first-received bit of a window is its MSB.
REQ-015 SHALL define reference window k as SEQ indices k..k+N-1 taken modulo 2^N (wrap-around), index k as MSB.
REQ-016 SHALL implement states FILL, SEARCH, TRACK.
REQ-017 In FILL it SHALL hold bit_ready=1, count accepted bits saturating at N, and enter SEARCH with k=0 on the acceptance that makes the count N.
REQ-018 In SEARCH it SHALL hold bit_ready=0 and compare reference window k with the window register, one k per cycle, starting k=0.
REQ-019 On a match at k it SHALL register pos=k, pulse pos_valid in the next cycle, set locked=1, and enter TRACK, giving pos_valid k+1 cycles after SEARCH entry.
REQ-020 On no match at k=2^N-1 it SHALL pulse miss in the next cycle, keep locked=0, and return to FILL with the count left at N, so the next accepted bit restarts SEARCH.
REQ-021 In TRACK it SHALL hold bit_ready=1; on each acceptance it SHALL compare the updated window with reference window (pos+1) mod 2^N.
REQ-022 On a TRACK match it SHALL set pos=(pos+1) mod 2^N and pulse pos_valid in the cycle after acceptance; 15 SHALL wrap to 0 for N=4.
REQ-023 On a TRACK mismatch it SHALL pulse slip in the cycle after acceptance, clear locked, leave pos unchanged, and enter SEARCH with k=0.
REQ-024 It SHALL never assert pos_valid, slip and miss in the same cycle.

Reset
REQ-025 While rst_n=0, regardless of clk and even mid-SEARCH, it SHALL set state=FILL, window=0, count=0, k=0, pos=0, and pos_valid=locked=slip=miss=0.
REQ-026 It SHALL drive bit_ready=0 during reset and 1 from the first clock edge after rst_n rises.

Structure
REQ-027 SHALL take the defaults of N and SEQ, the state encoding, and a window-extraction function (SEQ, k -> N bits) from a shared package dbj_pkg, shared with the generator.
REQ-028 SHALL instantiate one sub-module, dbj_shift_reg: an N-bit serial-in/parallel-out register with an enable and the same async active-low reset.

Verification (N=4, default SEQ)
REQ-029 After reset, feed 1,1,0,1 -> SEARCH entered; pos=7 with pos_valid 8 cycles later; locked=1.
REQ-030 Locked at 7, feed 0 -> pos=8 with pos_valid one cycle after acceptance; slip=0.
REQ-031 Feed 1,0,0,0 (pos=15), then 0 -> pos=0 with pos_valid (wrap-around).
REQ-032 Locked at 7, feed 1 -> slip pulse, locked=0, bit_ready=0; pos=10 with pos_valid 11 cycles after SEARCH entry.
REQ-033 SEQ=16'h0000, feed 1,1,1,1 -> miss pulse after 16 SEARCH cycles; pos_valid never asserted; state FILL.
REQ-034 Assert rst_n=0 at SEARCH cycle 3 -> all outputs at reset values immediately; 4 fresh bits are needed before the next SEARCH.

Source files
------------

// File: rtl/dbj_pkg.sv
// Shared de Bruijn definitions used by both the generator and the decoder:
// default geometry, FSM encoding and reference-window extraction.
package dbj_pkg;

    localparam int          DBJ_N   = 4;
    localparam logic [15:0] DBJ_SEQ = 16'b0000_1001_1010_1111;

    // Widest window the extraction helper supports; sequences up to 2^MAX_N bits.
    localparam int MAX_N   = 8;
    localparam int MAX_LEN = 1 << MAX_N;
    localparam int WIDX    = $clog2(MAX_N);
    localparam int SIDX    = $clog2(MAX_LEN);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRACK  = 2'd2
    } dbj_state_t;

    // Window k of an n-bit sequence held right-aligned in seq, sequence index 0
    // at bit (2^n - 1). Index k becomes the window MSB; indices wrap modulo 2^n.
    function automatic logic [MAX_N-1:0] ref_window(input logic [MAX_LEN-1:0] seq,
                                                    input int n, input int k);
        logic [MAX_N-1:0] w;
        int               len;
        w   = '0;
        len = 1 << n;
        for (int j = 0; j < MAX_N; j++) begin
            if (j < n) begin
                w[WIDX'(n - 1 - j)] = seq[SIDX'(len - 1 - ((k + j) % len))];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dbj_shift_reg.sv
// N-bit serial-in / parallel-out register; new bits enter at the LSB so the
// oldest bit ends up in the MSB.
module dbj_shift_reg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         din,
    output logic [N-1:0] q
);

    logic [N-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= {q_reg[N-2:0], din};
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/dbj_decoder.sv
// De Bruijn position decoder: collects N bits, searches the reference windows
// one per cycle, then tracks the position bit by bit until a prediction fails.
module dbj_decoder
    import dbj_pkg::*;
#(
    parameter int              N   = DBJ_N,
    parameter logic [2**N-1:0] SEQ = DBJ_SEQ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic         bit_ready,
    output logic [N-1:0] pos,
    output logic         pos_valid,
    output logic         locked,
    output logic         slip,
    output logic         miss
);

    localparam int              L        = 1 << N;
    localparam int              CW       = $clog2(N + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(N);
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

    dbj_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [N-1:0]  k_reg, k_next;
    logic [N-1:0]  pos_reg, pos_next;
    logic          pos_valid_reg, pos_valid_next;
    logic          locked_reg, locked_next;
    logic          slip_reg, slip_next;
    logic          miss_reg, miss_next;
    logic          rdy_en_reg;

    logic             accept;
    logic [N-1:0]     win;
    logic [N-1:0]     win_shift;
    logic [N-1:0]     pos_inc;
    logic [MAX_N-1:0] ref_win [L];

    // Constant table of every reference window, indexed by position.
    for (genvar gi = 0; gi < L; gi++) begin : g_ref
        assign ref_win[gi] = ref_window(MAX_LEN'(SEQ), N, gi);
    end

    dbj_shift_reg #(.N(N)) u_win (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .din   (bit_in),
        .q     (win)
    );

    assign accept    = bit_valid && bit_ready;
    assign win_shift = {win[N-2:0], bit_in};
    assign pos_inc   = pos_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_FILL;
            cnt_reg       <= '0;
            k_reg         <= '0;
            pos_reg       <= '0;
            pos_valid_reg <= 1'b0;
            locked_reg    <= 1'b0;
            slip_reg      <= 1'b0;
            miss_reg      <= 1'b0;
            rdy_en_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            k_reg         <= k_next;
            pos_reg       <= pos_next;
            pos_valid_reg <= pos_valid_next;
            locked_reg    <= locked_next;
            slip_reg      <= slip_next;
            miss_reg      <= miss_next;
            rdy_en_reg    <= 1'b1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        k_next         = k_reg;
        pos_next       = pos_reg;
        pos_valid_next = 1'b0;
        locked_next    = locked_reg;
        slip_next      = 1'b0;
        miss_next      = 1'b0;
        case (state_reg)
            ST_FILL: begin
                if (accept) begin
                    if (cnt_reg != CNT_FULL) cnt_next = cnt_reg + 1'b1;
                    // Count is left saturated after a miss so one new bit re-searches.
                    if (cnt_reg >= CNT_LAST) begin
                        state_next = ST_SEARCH;
                        k_next     = '0;
                    end
                end
            end
            ST_SEARCH: begin
                if (ref_win[k_reg] == MAX_N'(win)) begin
                    pos_next       = k_reg;
                    pos_valid_next = 1'b1;
                    locked_next    = 1'b1;
                    state_next     = ST_TRACK;
                end else if (k_reg == '1) begin
                    miss_next   = 1'b1;
                    locked_next = 1'b0;
                    state_next  = ST_FILL;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            ST_TRACK: begin
                if (accept) begin
                    if (ref_win[pos_inc] == MAX_N'(win_shift)) begin
                        pos_next       = pos_inc;
                        pos_valid_next = 1'b1;
                    end else begin
                        slip_next   = 1'b1;
                        locked_next = 1'b0;
                        state_next  = ST_SEARCH;
                        k_next      = '0;
                    end
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    always_comb begin
        bit_ready = rdy_en_reg && (state_reg != ST_SEARCH);
    end

    assign pos       = pos_reg;
    assign pos_valid = pos_valid_reg;
    assign locked    = locked_reg;
    assign slip      = slip_reg;
    assign miss      = miss_reg;

endmodule

// File: tb/tb_dbj_decoder.sv
// Directed bench for dbj_decoder: lock, tracking table with wrap, slip/re-search,
// search miss on an all-zero sequence, and reset asserted mid-search.
module tb_dbj_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       bit_in, bit_valid, bit_ready;
    logic [3:0] pos;
    logic       pos_valid, locked, slip, miss;
    logic       bit_in_z, bit_valid_z, bit_ready_z;
    logic [3:0] pos_z;
    logic       pos_valid_z, locked_z, slip_z, miss_z;

    int n_checks = 0;
    int n_fail   = 0;

    dbj_decoder #(.N(4), .SEQ(16'b0000_1001_1010_1111)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .pos(pos), .pos_valid(pos_valid),
        .locked(locked), .slip(slip), .miss(miss)
    );

    dbj_decoder #(.N(4), .SEQ(16'h0000)) dut_z (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in_z), .bit_valid(bit_valid_z),
        .bit_ready(bit_ready_z), .pos(pos_z), .pos_valid(pos_valid_z),
        .locked(locked_z), .slip(slip_z), .miss(miss_z)
    );

    typedef struct {
        logic b;
        int   exp_pos;
    } vec_t;
    vec_t tv [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Pulses are mutually exclusive; the all-zero sequence must never produce a match.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks += 2;
            if (int'(pos_valid) + int'(slip) + int'(miss) > 1) begin
                n_fail++;
                $display("FAIL pulse_overlap: pv=%0b slip=%0b miss=%0b", pos_valid, slip, miss);
            end
            if (pos_valid_z !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_seq_pos_valid: got %0b expected 0", pos_valid_z);
            end
        end
    end

    task automatic do_reset();
        bit_valid = 0; bit_valid_z = 0; bit_in = 0; bit_in_z = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk); @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic accept_bit(input bit z, input logic b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(z ? bit_ready_z : bit_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        if (z) begin bit_in_z = b; bit_valid_z = 1; end
        else   begin bit_in   = b; bit_valid   = 1; end
        @(posedge clk); #1;
        bit_valid = 0; bit_valid_z = 0;
        $display("bit %0d -> dut%s pos=%0d pv=%0b lk=%0b slip=%0b miss=%0b", b, z ? "_z" : "",
                 z ? pos_z : pos, z ? pos_valid_z : pos_valid, z ? locked_z : locked,
                 z ? slip_z : slip, z ? miss_z : miss);
    endtask

    // Cycles from the current edge to the edge that raises pos_valid (sel 0) or miss_z (sel 1).
    task automatic wait_event(input int sel, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if ((sel == 0) ? pos_valid : miss_z) begin
                n = i;
                break;
            end
        end
    endtask

    int n;

    initial begin
        tv[0] = '{1'b0, 8};
        tv[1] = '{1'b1, 9};
        tv[2] = '{1'b1, 10};
        tv[3] = '{1'b1, 11};
        tv[4] = '{1'b1, 12};
        tv[5] = '{1'b0, 13};
        tv[6] = '{1'b0, 14};
        tv[7] = '{1'b0, 15};
        tv[8] = '{1'b0, 0};

        bit_in = 0; bit_valid = 0; bit_in_z = 0; bit_valid_z = 0;
        rst_n = 1;
        #1 rst_n = 0;
        #11;
        chk("rst_bit_ready", bit_ready, 0);
        chk("rst_pos", pos, 0);
        chk("rst_pos_valid", pos_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_slip_miss", {slip, miss}, 0);
        chk("rst_bit_ready_z", bit_ready_z, 0);
        @(negedge clk); rst_n = 1; #1;
        chk("ready_before_edge", bit_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", bit_ready, 1);

        // Lock at 7, then tracking table including 15 -> 0 wrap.
        accept_bit(0, 1); accept_bit(0, 1); accept_bit(0, 0); accept_bit(0, 1);
        chk("search_ready_low", bit_ready, 0);
        wait_event(0, n);
        chk("lock_latency", n, 8);
        chk("lock_pos", pos, 7);
        chk("lock_locked", locked, 1);
        @(posedge clk); #1;
        chk("pv_one_cycle", pos_valid, 0);
        for (int i = 0; i < 9; i++) begin
            accept_bit(0, tv[i].b);
            chk($sformatf("trk%0d_pv", i), pos_valid, 1);
            chk($sformatf("trk%0d_pos", i), pos, tv[i].exp_pos);
            chk($sformatf("trk%0d_slip", i), slip, 0);
            chk($sformatf("trk%0d_locked", i), locked, 1);
        end

        // Search to the last window, then wrap while tracking.
        do_reset();
        accept_bit(0, 1); accept_bit(0, 0); accept_bit(0, 0); accept_bit(0, 0);
        wait_event(0, n);
        chk("k15_latency", n, 16);
        chk("k15_pos", pos, 15);
        accept_bit(0, 0);
        chk("wrap_pv", pos_valid, 1);
        chk("wrap_pos", pos, 0);

        // Slip from 7 and re-search to 10.
        do_reset();
        accept_bit(0, 1); accept_bit(0, 1); accept_bit(0, 0); accept_bit(0, 1);
        wait_event(0, n);
        accept_bit(0, 1);
        chk("slip_pulse", slip, 1);
        chk("slip_locked", locked, 0);
        chk("slip_ready", bit_ready, 0);
        chk("slip_pos_kept", pos, 7);
        chk("slip_pv", pos_valid, 0);
        wait_event(0, n);
        chk("research_latency", n, 11);
        chk("research_pos", pos, 10);
        chk("research_locked", locked, 1);

        // Reset asserted between edges during SEARCH cycle 3.
        do_reset();
        accept_bit(0, 1); accept_bit(0, 1); accept_bit(0, 0); accept_bit(0, 1);
        wait_event(0, n);
        accept_bit(0, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("midrst_pos", pos, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_ready", bit_ready, 0);
        chk("midrst_pulses", {pos_valid, slip, miss}, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        accept_bit(0, 1);
        chk("refill1_ready", bit_ready, 1);
        accept_bit(0, 1);
        chk("refill2_ready", bit_ready, 1);
        accept_bit(0, 0);
        chk("refill3_ready", bit_ready, 1);
        accept_bit(0, 1);
        chk("refill4_ready", bit_ready, 0);
        wait_event(0, n);
        chk("refill_latency", n, 8);
        chk("refill_pos", pos, 7);

        // All-zero reference: 1111 never matches.
        do_reset();
        accept_bit(1, 1); accept_bit(1, 1); accept_bit(1, 1); accept_bit(1, 1);
        chk("z_search_ready", bit_ready_z, 0);
        wait_event(1, n);
        chk("miss_latency", n, 16);
        chk("miss_locked", locked_z, 0);
        chk("miss_ready", bit_ready_z, 1);
        @(posedge clk); #1;
        chk("miss_one_cycle", miss_z, 0);
        accept_bit(1, 1);
        chk("miss_restart", bit_ready_z, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
